// File: rtl/sleep_cycle_scheduler.sv
// Wake/sleep cycle sequencer for the vital energy resource.
// Turns energy level, stimuli and a slow tick into registered inc/dec/fast/setval strobes.
module sleep_cycle_scheduler #(
  parameter logic [7:0] DROWSY_TH    = 8'd64,
  parameter logic [7:0] DEEP_TH      = 8'd160,
  parameter logic [7:0] WAKE_TH      = 8'd240,
  parameter logic [7:0] DROWSY_TICKS = 8'd8,
  parameter logic [7:0] WAKE_PERSIST = 8'd4,
  parameter logic [7:0] WAKE_TICKS   = 8'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [7:0] vital_energy,
  input  logic       vital_energy_zero,
  input  logic       wake_stimulus,
  input  logic       action_active,
  output logic       inc,
  output logic       dec,
  output logic       fast,
  output logic       setval,
  output logic       sleeping,
  output logic [2:0] sleep_state
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STATE_W = 3;
  localparam logic [7:0]  SETVAL_LEVEL = 8'd64;

  typedef enum logic [STATE_W-1:0] {
    ST_AWAKE  = 3'd0,
    ST_DROWSY = 3'd1,
    ST_ASLEEP = 3'd2,
    ST_DEEP   = 3'd3,
    ST_WAKING = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               inc_d, dec_d, fast_d, setval_d;
  logic               sleeping_d;

  // Terminal counts for the dwell counter in each timed state
  logic [CNT_W-1:0]   drowsy_last, persist_last, waking_last;
  assign drowsy_last  = DROWSY_TICKS - CNT_W'(1);
  assign persist_last = WAKE_PERSIST - CNT_W'(1);
  assign waking_last  = WAKE_TICKS - CNT_W'(1);

  // State, dwell counter and strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_AWAKE;
      cnt_q    <= '0;
      inc      <= 1'b0;
      dec      <= 1'b0;
      fast     <= 1'b0;
      setval   <= 1'b0;
      sleeping <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inc      <= inc_d;
      dec      <= dec_d;
      fast     <= fast_d;
      setval   <= setval_d;
      sleeping <= sleeping_d;
    end
  end

  assign sleep_state = state_q;

  // Next-state and strobe decode; everything holds except on tick cycles
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    fast_d   = 1'b0;
    setval_d = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_AWAKE: begin
          dec_d  = 1'b1;
          fast_d = action_active;
          if (vital_energy_zero) begin
            state_d = ST_ASLEEP;
            cnt_d   = '0;
          end else if (vital_energy < DROWSY_TH) begin
            state_d = ST_DROWSY;
            cnt_d   = '0;
          end
        end

        ST_DROWSY: begin
          dec_d = 1'b1;
          if (vital_energy_zero) begin
            state_d = ST_ASLEEP;
            cnt_d   = '0;
          end else if (wake_stimulus) begin
            state_d = ST_AWAKE;
            cnt_d   = '0;
          end else if (cnt_q == drowsy_last) begin
            state_d = ST_ASLEEP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_ASLEEP: begin
          inc_d = 1'b1;
          if (wake_stimulus) begin
            state_d = ST_WAKING;
            cnt_d   = '0;
          end else if (vital_energy >= DEEP_TH) begin
            state_d = ST_DEEP;
            cnt_d   = '0;
          end
        end

        ST_DEEP: begin
          inc_d  = 1'b1;
          fast_d = 1'b1;
          if (vital_energy >= WAKE_TH) begin
            state_d = ST_WAKING;
            cnt_d   = '0;
          end else if (wake_stimulus) begin
            if (cnt_q == persist_last) begin
              state_d = ST_WAKING;
              cnt_d   = '0;
              // A forced wake from low energy reloads the resource instead of stepping it
              if (vital_energy < SETVAL_LEVEL) begin
                setval_d = 1'b1;
                inc_d    = 1'b0;
                fast_d   = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end

        ST_WAKING: begin
          if (cnt_q == waking_last) begin
            state_d = ST_AWAKE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_AWAKE;
          cnt_d   = '0;
        end
      endcase
    end

    sleeping_d = (state_d == ST_ASLEEP) || (state_d == ST_DEEP);
  end

  // Strobe exclusivity guarantees seen by the resource counter
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(inc && dec));
      assert (!fast || inc || dec);
      assert (!setval || (!inc && !dec));
    end
  end

endmodule

// File: tb/tb_sleep_cycle_scheduler.sv
// Randomized scoreboard bench for sleep_cycle_scheduler against a rule-level model.
module tb_sleep_cycle_scheduler;

  localparam int DROWSY_TH    = 64;
  localparam int DEEP_TH      = 160;
  localparam int WAKE_TH      = 240;
  localparam int DROWSY_TICKS = 8;
  localparam int WAKE_PERSIST = 4;
  localparam int WAKE_TICKS   = 2;

  localparam int S_AWAKE  = 0;
  localparam int S_DROWSY = 1;
  localparam int S_ASLEEP = 2;
  localparam int S_DEEP   = 3;
  localparam int S_WAKING = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] vital_energy = 8'd0;
  logic       vital_energy_zero = 1'b0;
  logic       wake_stimulus = 1'b0;
  logic       action_active = 1'b0;
  logic       inc, dec, fast, setval, sleeping;
  logic [2:0] sleep_state;

  sleep_cycle_scheduler dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tick              (tick),
    .vital_energy      (vital_energy),
    .vital_energy_zero (vital_energy_zero),
    .wake_stimulus     (wake_stimulus),
    .action_active     (action_active),
    .inc               (inc),
    .dec               (dec),
    .fast              (fast),
    .setval            (setval),
    .sleeping          (sleeping),
    .sleep_state       (sleep_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       inc;
    logic       dec;
    logic       fast;
    logic       setval;
    logic [2:0] st;
    logic       slp;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] last_st = 3'd0;
  logic       tick_q;

  // Model state: phase plus how long it has lasted, in ticks
  int m_state      = S_AWAKE;
  int drowsy_spent = 0;
  int wake_run     = 0;
  int waking_spent = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Apply the wake/sleep rules to one tick and queue the response expected next cycle
  task automatic model_tick(input logic [7:0] ve, input logic z, input logic ws, input logic aa);
    exp_t e;
    int   ns;
    e  = '0;
    ns = m_state;
    case (m_state)
      S_AWAKE: begin
        e.dec  = 1'b1;
        e.fast = aa;
        if (z) ns = S_ASLEEP;
        else if (int'(ve) < DROWSY_TH) ns = S_DROWSY;
      end
      S_DROWSY: begin
        e.dec = 1'b1;
        if (z) ns = S_ASLEEP;
        else if (ws) ns = S_AWAKE;
        else if (drowsy_spent + 1 == DROWSY_TICKS) ns = S_ASLEEP;
        else drowsy_spent++;
      end
      S_ASLEEP: begin
        e.inc = 1'b1;
        if (ws) ns = S_WAKING;
        else if (int'(ve) >= DEEP_TH) ns = S_DEEP;
      end
      S_DEEP: begin
        e.inc  = 1'b1;
        e.fast = 1'b1;
        wake_run = ws ? wake_run + 1 : 0;
        if (int'(ve) >= WAKE_TH) ns = S_WAKING;
        else if (wake_run == WAKE_PERSIST) begin
          ns = S_WAKING;
          if (int'(ve) < 64) begin
            e.setval = 1'b1;
            e.inc    = 1'b0;
            e.fast   = 1'b0;
          end
        end
      end
      S_WAKING: begin
        if (waking_spent + 1 == WAKE_TICKS) ns = S_AWAKE;
        else waking_spent++;
      end
      default: ns = S_AWAKE;
    endcase
    if (ns != m_state) begin
      drowsy_spent = 0;
      wake_run     = 0;
      waking_spent = 0;
    end
    m_state = ns;
    e.st  = 3'(ns);
    e.slp = (ns == S_ASLEEP) || (ns == S_DEEP);
    q.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick;
  end

  // Monitor: every cycle after a tick pops one expectation; other cycles must be quiet
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_st = 3'd0;
    end else if (tick_q) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow: got output cycle, want queued expectation at %0t", $time);
      end else begin
        e = q.pop_front();
        check("strobes{inc,dec,fast,setval}", int'({inc, dec, fast, setval}),
              int'({e.inc, e.dec, e.fast, e.setval}));
        check("sleep_state", int'(sleep_state), int'(e.st));
        check("sleeping", int'(sleeping), int'(e.slp));
        last_st = e.st;
      end
    end else begin
      check("idle_strobes", int'({inc, dec, fast, setval}), 0);
      check("idle_sleep_state", int'(sleep_state), int'(last_st));
    end
  end

  task automatic cyc(input bit t, input logic [7:0] ve, input logic ws, input logic aa);
    tick              = t;
    vital_energy      = ve;
    vital_energy_zero = (ve == 8'd0);
    wake_stimulus     = ws;
    action_active     = aa;
    if (t) model_tick(ve, ve == 8'd0, ws, aa);
    @(negedge clk);
  endtask

  // n ticks, alternating spaced and back-to-back
  task automatic ticks(input int n, input logic [7:0] ve, input logic ws, input logic aa);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, ve, ws, aa);
      if (i % 2 == 1) cyc(1'b0, ve, ws, aa);
    end
  endtask

  task automatic reset_now();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_inc", int'(inc), 0);
    check("rst_dec", int'(dec), 0);
    check("rst_fast", int'(fast), 0);
    check("rst_setval", int'(setval), 0);
    check("rst_sleeping", int'(sleeping), 0);
    check("rst_sleep_state", int'(sleep_state), 0);
    tick = 1'b0;
    q.delete();
    m_state      = S_AWAKE;
    drowsy_spent = 0;
    wake_run     = 0;
    waking_spent = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       ws_r;
    logic [7:0] ve_r;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 8'd128, 1'b0, 1'b0);

    // Plain awake drain
    ticks(10, 8'd128, 1'b0, 1'b0);
    // Drowsy then asleep after full dwell
    ticks(1, 8'd63, 1'b0, 1'b0);
    ticks(8, 8'd63, 1'b0, 1'b0);
    // Wake out of asleep, back to awake, then drowsy interrupted at its third tick
    ticks(1, 8'd63, 1'b1, 1'b0);
    ticks(2, 8'd100, 1'b0, 1'b0);
    ticks(1, 8'd63, 1'b0, 1'b0);
    ticks(2, 8'd63, 1'b0, 1'b0);
    ticks(1, 8'd63, 1'b1, 1'b0);
    ticks(1, 8'd63, 1'b0, 1'b0);
    ticks(8, 8'd63, 1'b0, 1'b0);
    // Deep sleep and natural wake
    ticks(1, 8'd160, 1'b0, 1'b0);
    ticks(3, 8'd200, 1'b0, 1'b0);
    ticks(1, 8'd240, 1'b0, 1'b0);
    ticks(2, 8'd100, 1'b0, 1'b0);
    // Collapse, deep, forced wake at low energy
    ticks(1, 8'd0, 1'b0, 1'b1);
    ticks(1, 8'd160, 1'b0, 1'b0);
    ticks(4, 8'd40, 1'b1, 1'b0);
    ticks(2, 8'd100, 1'b0, 1'b0);
    // Stimulus dropped at the third tick restarts the persistence count
    ticks(1, 8'd0, 1'b0, 1'b1);
    ticks(1, 8'd160, 1'b0, 1'b0);
    ticks(2, 8'd40, 1'b1, 1'b0);
    ticks(1, 8'd40, 1'b0, 1'b0);
    ticks(3, 8'd40, 1'b1, 1'b0);
    ticks(1, 8'd40, 1'b1, 1'b0);
    ticks(2, 8'd100, 1'b0, 1'b0);
    // Reset while deep and strobing
    ticks(1, 8'd0, 1'b0, 1'b0);
    ticks(1, 8'd160, 1'b0, 1'b0);
    tick = 1'b1;
    vital_energy = 8'd200;
    vital_energy_zero = 1'b0;
    reset_now();
    cyc(1'b0, 8'd128, 1'b0, 1'b0);

    // Random phase with threshold-biased energy and sticky stimulus
    ws_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0: ve_r = 8'd0;
        1: ve_r = 8'd63;
        2: ve_r = 8'd64;
        3: ve_r = 8'd159;
        4: ve_r = 8'd160;
        5: ve_r = 8'd239;
        6: ve_r = 8'd240;
        default: ve_r = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) == 0) ws_r = ~ws_r;
      cyc(1'b1, ve_r, ws_r, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) cyc(1'b0, ve_r, ws_r, 1'b0);
      if (i == 700) begin
        reset_now();
        cyc(1'b0, 8'd128, 1'b0, 1'b0);
      end
    end

    cyc(1'b0, 8'd128, 1'b0, 1'b0);
    cyc(1'b0, 8'd128, 1'b0, 1'b0);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
